// File: rtl/mem_access.sv
// mem_access: MIPS memory-stage data access unit driving an SRAM-like data bus.
// Issues one bus transaction per memop, stalls until completion, extends load data.
module mem_access (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [3:0]  in_memop,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_writereg,
  input  logic        in_regwrite,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic        out_valid,
  output logic [31:0] out_rd,
  output logic [4:0]  out_writereg,
  output logic        out_regwrite,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic [31:0] exc_badvaddr
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_n;
  logic [3:0]  op_q;
  logic [31:0] addr_q, wdata_q;
  logic [4:0]  wreg_q;
  logic        rw_q, discard;
  logic [3:0]  op;
  logic [31:0] a, wd, ld;
  logic [1:0]  size;
  logic [7:0]  b;
  logic [15:0] h;
  logic        idle, is_load, is_store, is_mem, misalign, issue, exc, done, keep;
  assign idle     = state == IDLE;
  assign op       = idle ? in_memop : op_q;
  assign a        = idle ? in_addr : addr_q;
  assign wd       = idle ? in_wdata : wdata_q;
  assign is_load  = op >= 4'd1 && op <= 4'd5;
  assign is_store = op >= 4'd6 && op <= 4'd8;
  assign is_mem   = is_load | is_store;
  assign size     = (op == 4'd1 || op == 4'd2 || op == 4'd6) ? 2'd0 :
                    (op == 4'd3 || op == 4'd4 || op == 4'd7) ? 2'd1 : 2'd2;
  assign misalign = (size == 2'd1 && a[0]) || (size == 2'd2 && a[1:0] != 2'b00);
  assign issue    = idle && in_valid && is_mem && !misalign && !flush;
  assign exc      = idle && in_valid && is_mem && misalign;
  assign done     = state == WAIT && bus_data_ok;
  assign keep     = done && !discard && !flush;
  assign b        = bus_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign h        = bus_rdata[{addr_q[1], 4'b0000} +: 16];
  assign ld       = op_q == 4'd1 ? {{24{b[7]}}, b} :
                    op_q == 4'd2 ? {24'b0, b} :
                    op_q == 4'd3 ? {{16{h[15]}}, h} :
                    op_q == 4'd4 ? {16'b0, h} : bus_rdata;
  always_comb begin
    bus_req      = issue || state == REQ;
    bus_wr       = bus_req && is_store;
    bus_size     = bus_req ? size : 2'd0;
    bus_addr     = a;
    bus_wstrb    = !bus_wr ? 4'b0000 :
                   size == 2'd0 ? 4'b0001 << a[1:0] :
                   size == 2'd1 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    bus_wdata    = !bus_wr ? 32'd0 :
                   size == 2'd0 ? {4{wd[7:0]}} :
                   size == 2'd1 ? {2{wd[15:0]}} : wd;
    stall        = issue || state == REQ || (state == WAIT && !bus_data_ok);
    out_valid    = idle ? in_valid && !flush && !issue : keep;
    out_rd       = keep && is_load ? ld : 32'd0;
    out_writereg = idle ? in_writereg : wreg_q;
    out_regwrite = idle ? out_valid && in_regwrite && !is_mem : keep && rw_q && is_load;
    exc_adel     = exc && is_load;
    exc_ades     = exc && is_store;
    exc_badvaddr = exc ? in_addr : 32'd0;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = issue ? (bus_addr_ok ? WAIT : REQ) : IDLE;
      REQ:     state_n = bus_addr_ok ? WAIT : REQ;
      default: state_n = bus_data_ok ? IDLE : WAIT;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      discard <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wreg_q  <= '0;
      rw_q    <= 1'b0;
    end else begin
      state <= state_n;
      // A flushed in-flight access must still drain; remember to drop its result
      if (idle || done) discard <= 1'b0;
      else if (flush) discard <= 1'b1;
      if (issue) begin
        op_q    <= in_memop;
        addr_q  <= in_addr;
        wdata_q <= in_wdata;
        wreg_q  <= in_writereg;
        rw_q    <= in_regwrite;
      end
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized self-checking bench for mem_access with a bus responder and reference model.
module tb_mem_access;
  logic        clk = 0, reset = 1;
  logic        in_valid = 0, in_regwrite = 0, flush = 0;
  logic [3:0]  in_memop = 0;
  logic [31:0] in_addr = 0, in_wdata = 0, bus_rdata = 0;
  logic [4:0]  in_writereg = 0;
  logic        bus_addr_ok = 0, bus_data_ok = 0;
  logic        bus_req, bus_wr, stall, out_valid, out_regwrite, exc_adel, exc_ades;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata, out_rd, exc_badvaddr;
  logic [4:0]  out_writereg;
  int checks = 0, errors = 0;

  mem_access dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_memop(in_memop), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_writereg(in_writereg), .in_regwrite(in_regwrite), .flush(flush),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .stall(stall), .out_valid(out_valid),
    .out_rd(out_rd), .out_writereg(out_writereg), .out_regwrite(out_regwrite),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_badvaddr(exc_badvaddr));

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!reset && bus_addr_ok && bus_data_ok && bus_req) begin
      errors++;
      $display("FAIL protocol: addr_ok and data_ok together while requesting (got 1, need 0)");
    end

  function automatic int op_size(input logic [3:0] op);
    return (op == 1 || op == 2 || op == 6) ? 1 : (op == 3 || op == 4 || op == 7) ? 2 : 4;
  endfunction

  task automatic go_idle();
    @(negedge clk);
    in_valid = 0; in_memop = 0; flush = 0; bus_addr_ok = 0; bus_data_ok = 0;
  endtask

  // One memop; addr_ok arrives al cycles after issue, data_ok dl cycles later, flush pulse at cycle fc (-1 none)
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] addr, wd, rdata,
                        input logic [4:0] wr, input logic rw, input int al, dl, fc);
    int n = op_size(op);
    int done = al + dl;
    bit is_ld = op <= 5;
    bit killed = fc >= 0 && fc <= done;
    int lane = addr % 4;
    logic [31:0] e_wdata, e_rd, v;
    logic [3:0] e_strb;
    logic [1:0] e_size;
    e_size = n == 1 ? 2'd0 : n == 2 ? 2'd1 : 2'd2;
    e_strb = is_ld ? 4'b0 : 4'(((1 << n) - 1) << lane);
    e_wdata = n == 1 ? (wd & 32'hFF) * 32'h0101_0101 : n == 2 ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    v = (rdata >> (8 * lane)) & (n == 4 ? 32'hFFFF_FFFF : (32'h1 << (8 * n)) - 1);
    if ((op == 1 && v >= 32'h80) || (op == 3 && v >= 32'h8000)) v = v - (32'h1 << (8 * n));
    e_rd = (killed || !is_ld) ? 32'd0 : v;
    for (int c = 0; c <= done; c++) begin
      @(negedge clk);
      in_valid = 1; in_memop = op; in_addr = addr; in_wdata = wd; in_writereg = wr; in_regwrite = rw;
      bus_addr_ok = c == al; bus_data_ok = c == done; flush = c == fc;
      bus_rdata = c == done ? rdata : $urandom;
      #1;
      checks += 3;
      if (bus_req !== (c <= al)) begin errors++; $display("FAIL %s bus_req c%0d: got %b need %b", name, c, bus_req, c <= al); end
      if (stall !== (c < done)) begin errors++; $display("FAIL %s stall c%0d: got %b need %b", name, c, stall, c < done); end
      if (out_valid !== (c == done && !killed)) begin errors++; $display("FAIL %s out_valid c%0d: got %b need %b", name, c, out_valid, c == done && !killed); end
      if (c <= al) begin
        checks += 5;
        if (bus_wr !== !is_ld) begin errors++; $display("FAIL %s bus_wr: got %b need %b", name, bus_wr, !is_ld); end
        if (bus_size !== e_size) begin errors++; $display("FAIL %s bus_size: got %0d need %0d", name, bus_size, e_size); end
        if (bus_addr !== addr) begin errors++; $display("FAIL %s bus_addr: got %h need %h", name, bus_addr, addr); end
        if (bus_wstrb !== e_strb) begin errors++; $display("FAIL %s bus_wstrb: got %b need %b", name, bus_wstrb, e_strb); end
        if (!is_ld && bus_wdata !== e_wdata) begin errors++; $display("FAIL %s bus_wdata: got %h need %h", name, bus_wdata, e_wdata); end
      end
      if (c == done) begin
        checks += 3;
        if (out_rd !== e_rd) begin errors++; $display("FAIL %s out_rd: got %h need %h", name, out_rd, e_rd); end
        if (out_regwrite !== (is_ld && rw && !killed)) begin errors++; $display("FAIL %s out_regwrite: got %b need %b", name, out_regwrite, is_ld && rw && !killed); end
        if (!killed && out_writereg !== wr) begin errors++; $display("FAIL %s out_writereg: got %0d need %0d", name, out_writereg, wr); end
      end
    end
    go_idle();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1; in_valid = 0;
    #1;
    checks += 6;
    if (bus_req !== 0) begin errors++; $display("FAIL reset bus_req: got %b need 0", bus_req); end
    if (bus_wr !== 0) begin errors++; $display("FAIL reset bus_wr: got %b need 0", bus_wr); end
    if (bus_wstrb !== 0) begin errors++; $display("FAIL reset bus_wstrb: got %b need 0", bus_wstrb); end
    if (stall !== 0) begin errors++; $display("FAIL reset stall: got %b need 0", stall); end
    if (out_valid !== 0) begin errors++; $display("FAIL reset out_valid: got %b need 0", out_valid); end
    if ({exc_adel, exc_ades} !== 0) begin errors++; $display("FAIL reset exc: got %b need 00", {exc_adel, exc_ades}); end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_plan_loads_stores();
    run_op("lb_plan", 4'd1, 32'h1003, 32'h0, 32'h80FF_FF7F, 5'd3, 1, 0, 1, -1);
    run_op("lhu_plan", 4'd4, 32'h2002, 32'h0, 32'hBEEF_1234, 5'd4, 1, 0, 1, -1);
    run_op("lh_plan", 4'd3, 32'h2002, 32'h0, 32'hBEEF_1234, 5'd5, 1, 1, 2, -1);
    run_op("sb_plan", 4'd6, 32'h11, 32'h0000_00AB, 32'h0, 5'd6, 1, 0, 1, -1);
    run_op("sh_hi", 4'd7, 32'h42, 32'h1234_5678, 32'h0, 5'd7, 0, 2, 1, -1);
    run_op("sw", 4'd8, 32'h40, 32'hDEAD_BEEF, 32'h0, 5'd8, 0, 0, 3, -1);
  endtask

  task automatic test_misalign(input string name, input logic [3:0] op, input logic [31:0] addr);
    bit st = op >= 6;
    @(negedge clk);
    in_valid = 1; in_memop = op; in_addr = addr; in_regwrite = 1; flush = 0;
    #1;
    checks += 6;
    if (exc_adel !== !st) begin errors++; $display("FAIL %s adel: got %b need %b", name, exc_adel, !st); end
    if (exc_ades !== st) begin errors++; $display("FAIL %s ades: got %b need %b", name, exc_ades, st); end
    if (exc_badvaddr !== addr) begin errors++; $display("FAIL %s badvaddr: got %h need %h", name, exc_badvaddr, addr); end
    if (bus_req !== 0) begin errors++; $display("FAIL %s bus_req: got %b need 0", name, bus_req); end
    if (stall !== 0) begin errors++; $display("FAIL %s stall: got %b need 0", name, stall); end
    if ({out_valid, out_regwrite} !== 2'b10) begin errors++; $display("FAIL %s valid/regwrite: got %b need 10", name, {out_valid, out_regwrite}); end
    go_idle();
  endtask

  task automatic test_flush();
    run_op("flush_req", 4'd5, 32'h3000, 32'h0, 32'h1111_2222, 5'd9, 1, 3, 2, 1);
    run_op("flush_wait", 4'd1, 32'h3001, 32'h0, 32'h0000_FF00, 5'd9, 1, 0, 3, 2);
    run_op("flush_dataok", 4'd5, 32'h3004, 32'h0, 32'h5555_AAAA, 5'd9, 1, 1, 1, 2);
    run_op("after_flush", 4'd2, 32'h3001, 32'h0, 32'h0000_FF00, 5'd10, 1, 0, 1, -1);
    @(negedge clk);
    in_valid = 1; in_memop = 4'd5; in_addr = 32'h3000; flush = 1;
    #1;
    checks += 3;
    if (bus_req !== 0) begin errors++; $display("FAIL flush_idle bus_req: got %b need 0", bus_req); end
    if (stall !== 0) begin errors++; $display("FAIL flush_idle stall: got %b need 0", stall); end
    if (out_valid !== 0) begin errors++; $display("FAIL flush_idle out_valid: got %b need 0", out_valid); end
    go_idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1; in_memop = 4'd5; in_addr = 32'h500; bus_addr_ok = 1;
    @(negedge clk);
    bus_addr_ok = 0; in_valid = 0; reset = 1;
    #1;
    checks += 2;
    if (bus_req !== 0) begin errors++; $display("FAIL reset_mid bus_req: got %b need 0", bus_req); end
    if (stall !== 0) begin errors++; $display("FAIL reset_mid stall: got %b need 0", stall); end
    @(negedge clk);
    reset = 0;
    run_op("lw_after_reset", 4'd5, 32'h504, 32'h0, 32'hCAFE_F00D, 5'd11, 1, 0, 1, -1);
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 12; i++) begin
      logic [3:0] op;
      logic v, rw, f;
      logic [4:0] wr;
      op = (i % 2 == 0) ? 4'd0 : 4'($urandom_range(9, 15));
      v = $urandom; rw = $urandom; f = $urandom_range(0, 3) == 0; wr = 5'($urandom);
      @(negedge clk);
      in_valid = v; in_memop = op; in_addr = $urandom; in_regwrite = rw; in_writereg = wr; flush = f;
      #1;
      checks += 5;
      if (out_valid !== (v && !f)) begin errors++; $display("FAIL pass out_valid: got %b need %b", out_valid, v && !f); end
      if (out_regwrite !== (v && rw && !f)) begin errors++; $display("FAIL pass regwrite: got %b need %b", out_regwrite, v && rw && !f); end
      if (out_writereg !== wr) begin errors++; $display("FAIL pass writereg: got %0d need %0d", out_writereg, wr); end
      if (out_rd !== 0) begin errors++; $display("FAIL pass out_rd: got %h need 0", out_rd); end
      if ({stall, bus_req} !== 2'b00) begin errors++; $display("FAIL pass stall/req: got %b need 00", {stall, bus_req}); end
    end
    go_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [3:0] op;
      logic [31:0] addr;
      int n, al, dl, fc;
      op = 4'($urandom_range(1, 8));
      n = op_size(op);
      addr = $urandom & ~(32'(n) - 1);
      al = $urandom_range(0, 3);
      dl = $urandom_range(1, 3);
      fc = $urandom_range(0, 4) == 0 ? $urandom_range(1, al + dl) : -1;
      run_op("rand", op, addr, $urandom, $urandom, 5'($urandom), 1'($urandom), al, dl, fc);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 0;
    test_reset();
    test_plan_loads_stores();
    test_misalign("lw_mis", 4'd5, 32'h1002);
    test_misalign("sh_mis", 4'd7, 32'h1001);
    test_misalign("lhu_mis", 4'd4, 32'h2003);
    test_misalign("sw_mis", 4'd8, 32'h2001);
    test_flush();
    test_reset_mid();
    test_passthrough();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
